risc5_irq_ctrl: RTL

RISC5_IRQ_CTRL -- requirements
Module: risc5_irq_ctrl

---
 rtl/risc5_irq_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/risc5_irq_ctrl.sv
// Vectored, priority-nesting interrupt controller for the risc5 core.
// Nesting/preemption is enabled by defining RISC5_IRQ_NEST_EN.
module risc5_irq_ctrl #(
  parameter int             NCH   = 8,
  parameter int             PCW   = 22,
  parameter int             DEPTH = 4,
  parameter logic [PCW-1:0] VBASE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] irq,
  input  logic           stall,
  input  logic           en_wr,
  input  logic           en_val,
  input  logic           mask_wr,
  input  logic [NCH-1:0] mask_din,
  input  logic [PCW-1:0] pc_in,
  input  logic [3:0]     flags_in,
  input  logic           rti,
  output logic           ack,
  output logic [PCW-1:0] vec,
  output logic [PCW-1:0] rpc,
  output logic [3:0]     rflags,
  output logic [4:0]     level,
  output logic [NCH-1:0] pend,
  output logic           full,
  output logic           rti_err
);

`ifdef RISC5_IRQ_NEST_EN
  localparam int DEP = DEPTH;
`else
  localparam int DEP = 1;
`endif

  if (NCH < 1 || NCH > 32 ||
      DEPTH < 1 || DEPTH > 16) begin : g_bad_param
    $error("risc5_irq_ctrl: bad NCH/DEPTH");
  end

  logic [NCH-1:0] irq_q;
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] pend_d;
  logic [NCH-1:0] mask_q;
  logic           enb_q;
  logic [4:0]     level_q;
  logic [4:0]     cur_q;
  logic           rti_err_q;

  logic [PCW-1:0] stk_pc_q  [DEP];
  logic [3:0]     stk_fl_q  [DEP];
  logic [4:0]     stk_cur_q [DEP];

  logic [NCH-1:0] elig;
  logic [NCH-1:0] win_oh;
  logic [4:0]     win;
  logic           lvl_ok;
  logic           full_w;
  logic           ack_w;
  logic           pop;
  logic [PCW-1:0] top_pc;
  logic [3:0]     top_fl;
  logic [4:0]     top_cur;

  assign elig = pend_q & mask_q;

  // Scan downwards so the lowest eligible index wins.
  always_comb begin
    win    = '0;
    win_oh = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win       = 5'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign full_w = (level_q == 5'(DEP));

`ifdef RISC5_IRQ_NEST_EN
  assign lvl_ok = (level_q == 5'd0) ||
                  (win < cur_q);
`else
  assign lvl_ok = (level_q == 5'd0);
`endif

  assign ack_w = enb_q & (|elig) & ~stall &
                 ~rti & ~full_w & lvl_ok;

  assign pop = rti & (level_q != 5'd0);

  always_comb begin
    top_pc  = '0;
    top_fl  = '0;
    top_cur = '0;
    for (int i = 0; i < DEP; i++) begin
      if (level_q == 5'(i + 1)) begin
        top_pc  = stk_pc_q[i];
        top_fl  = stk_fl_q[i];
        top_cur = stk_cur_q[i];
      end
    end
  end

  // A fresh edge on the winning channel re-arms it.
  always_comb begin
    pend_d = pend_q;
    if (ack_w) pend_d = pend_d & ~win_oh;
    pend_d = pend_d | (irq & ~irq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      enb_q     <= 1'b0;
      level_q   <= '0;
      cur_q     <= '0;
      rti_err_q <= 1'b0;
      for (int i = 0; i < DEP; i++) begin
        stk_pc_q[i]  <= '0;
        stk_fl_q[i]  <= '0;
        stk_cur_q[i] <= '0;
      end
    end else begin
      irq_q     <= irq;
      pend_q    <= pend_d;
      rti_err_q <= rti & (level_q == 5'd0);
      if (en_wr)   enb_q  <= en_val;
      if (mask_wr) mask_q <= mask_din;
      if (ack_w) begin
        for (int i = 0; i < DEP; i++) begin
          if (level_q == 5'(i)) begin
            stk_pc_q[i]  <= pc_in;
            stk_fl_q[i]  <= flags_in;
            stk_cur_q[i] <= cur_q;
          end
        end
        cur_q   <= win;
        level_q <= level_q + 5'd1;
      end else if (pop) begin
        cur_q   <= top_cur;
        level_q <= level_q - 5'd1;
      end
    end
  end

  assign ack     = ack_w;
  assign vec     = ack_w ? (VBASE + PCW'(win)) : '0;
  assign rpc     = top_pc;
  assign rflags  = top_fl;
  assign level   = level_q;
  assign pend    = pend_q;
  assign full    = full_w;
  assign rti_err = rti_err_q;

endmodule
